consolidation_arbiter: RTL and testbench



---
 rtl/consolidation_arbiter.sv | 169 ++++++++++++++++
 tb/tb_consolidation_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/consolidation_arbiter.sv
// consolidation_arbiter
//   Shares one 2-bit-in / 8-bit-out packer between NREQ serial requesters.
//   A requester is granted round-robin for a whole byte (SYMS symbols), so
//   every packed byte has exactly one source. The owner of each byte is
//   queued in a tag FIFO and replayed when the packer strobes a finished byte.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req_valid/req_sym per-requester symbol offer (symbol i on bits [2i+1:2i])
//   req_ready         per-requester accept, only the granted bit can be high
//   cons_din(_en)     registered symbol stream to the packer
//   cons_dout_en      packer byte-complete strobe
//   tag_id/tag_vld    owner of the byte reported by the previous strobe
//   busy              high while a burst is in progress
//   tag_err           sticky: byte strobe arrived with no owner queued
module consolidation_arbiter #(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int SYMS      = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_sym,
    output logic [NREQ-1:0]   req_ready,
    output logic [1:0]        cons_din,
    output logic              cons_din_en,
    input  logic              cons_dout_en,
    output logic [IDW-1:0]    tag_id,
    output logic              tag_vld,
    output logic              busy,
    output logic              tag_err
);

    localparam int CNT_W = $clog2(SYMS) + 1;
    localparam int CRD_W = $clog2(TAG_DEPTH) + 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q;
    logic [IDW-1:0]   gnt_q;
    logic [IDW-1:0]   last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CRD_W-1:0] credits_q;
    logic [CRD_W-1:0] fifo_cnt_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [IDW-1:0]   tag_mem [TAG_DEPTH];
    logic [1:0]       cons_din_q;
    logic             cons_din_en_q;
    logic [IDW-1:0]   tag_id_q;
    logic             tag_vld_q;
    logic             tag_err_q;

    logic             grant_found;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   cand_id;
    logic             do_grant;
    logic             accept;
    logic             last_sym;
    logic             pop;
    logic [1:0]       sym_sel;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Round-robin search starting just after the last owner.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_id     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_id = IDW'((int'(last_q) + i) % NREQ);
            if (!grant_found && req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_id    = cand_id;
            end
        end
    end

    // Credits are reserved at grant time, so a push can never overflow the FIFO.
    assign do_grant = (state_q == IDLE) && grant_found && (credits_q < CRD_W'(TAG_DEPTH));
    assign accept   = (state_q == BURST) && req_valid[gnt_q];
    assign last_sym = accept && (cnt_q == CNT_W'(SYMS - 1));
    assign pop      = cons_dout_en && (fifo_cnt_q != '0);
    assign sym_sel  = req_sym[{gnt_q, 1'b0} +: 2];

    always_comb begin
        req_ready = '0;
        if (state_q == BURST) begin
            req_ready[gnt_q] = req_valid[gnt_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            last_q        <= IDW'(NREQ - 1);
            cnt_q         <= '0;
            credits_q     <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cons_din_q    <= '0;
            cons_din_en_q <= 1'b0;
            tag_id_q      <= '0;
            tag_vld_q     <= 1'b0;
            tag_err_q     <= 1'b0;
        end else begin
            cons_din_en_q <= accept;
            if (accept) begin
                cons_din_q <= sym_sel;
            end

            case (state_q)
                IDLE: begin
                    if (do_grant) begin
                        gnt_q   <= grant_id;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (last_sym) begin
                        cnt_q   <= '0;
                        last_q  <= gnt_q;
                        state_q <= IDLE;
                    end else if (accept) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (last_sym) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
                tag_id_q <= tag_mem[rd_ptr_q];
            end
            tag_vld_q  <= pop;
            fifo_cnt_q <= fifo_cnt_q + CRD_W'(last_sym) - CRD_W'(pop);
            credits_q  <= credits_q + CRD_W'(do_grant) - CRD_W'(pop);

            if (cons_dout_en && (fifo_cnt_q == '0)) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    // Tag storage is plain data and needs no reset; occupancy guards reads.
    always_ff @(posedge clk) begin
        if (last_sym) begin
            tag_mem[wr_ptr_q] <= gnt_q;
        end
    end

    assign cons_din    = cons_din_q;
    assign cons_din_en = cons_din_en_q;
    assign tag_id      = tag_id_q;
    assign tag_vld     = tag_vld_q;
    assign tag_err     = tag_err_q;
    assign busy        = (state_q == BURST);

endmodule

// File: tb/tb_consolidation_arbiter.sv
// Bench for consolidation_arbiter: scripted grant scenarios with a
// scoreboard of expected packer symbols and expected byte owners.
module tb_consolidation_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_sym;
    logic [NREQ-1:0]   req_ready;
    logic [1:0]        cons_din;
    logic              cons_din_en;
    logic              cons_dout_en;
    logic [IDW-1:0]    tag_id;
    logic              tag_vld;
    logic              busy;
    logic              tag_err;

    int n_checks;
    int n_errors;

    logic [1:0]     sym_q [$];
    logic [IDW-1:0] tag_q [$];
    int             exp_idx [NREQ];
    int             nxt [NREQ];

    consolidation_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .SYMS(4), .TAG_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_sym(req_sym),
        .req_ready(req_ready),
        .cons_din(cons_din),
        .cons_din_en(cons_din_en),
        .cons_dout_en(cons_dout_en),
        .tag_id(tag_id),
        .tag_vld(tag_vld),
        .busy(busy),
        .tag_err(tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Symbol k of requester i's stream.
    function automatic logic [1:0] sym_of(input int i, input int k);
        return 2'((k + i + 3) % 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_syms(input int g, input int n);
        for (int k = 0; k < n; k++) begin
            sym_q.push_back(sym_of(g, exp_idx[g]));
            exp_idx[g]++;
        end
    endtask

    // Entry: DUT idle and requester g wins the next grant.
    task automatic run_burst(input int g, input bit pop_en, input logic [IDW-1:0] pop_tag);
        push_syms(g, 4);
        if (pop_en) begin
            tag_q.push_back(pop_tag);
            cons_dout_en = 1'b1;
        end
        tick();
        cons_dout_en = 1'b0;
        check_eq("grant_tagvld", tag_vld, pop_en);
        for (int k = 0; k < 4; k++) begin
            check_eq("burst_rdy", req_ready, 32'(1 << g));
            check_eq("burst_busy", busy, 1);
            tick();
        end
        check_eq("end_busy", busy, 0);
        check_eq("end_rdy", req_ready, 0);
    endtask

    task automatic pulse_dout(input bit exp_vld, input logic [IDW-1:0] exp_tag);
        if (exp_vld) tag_q.push_back(exp_tag);
        cons_dout_en = 1'b1;
        tick();
        cons_dout_en = 1'b0;
        check_eq("pulse_vld", tag_vld, exp_vld);
        tick();
        check_eq("pulse_vld_1cyc", tag_vld, 0);
    endtask

    // Requester front-ends: advance a stream only when its symbol was taken.
    initial begin : feeder
        logic [NREQ-1:0] acc;
        for (int i = 0; i < NREQ; i++) begin
            nxt[i] = 0;
            req_sym[2*i +: 2] = sym_of(i, 0);
        end
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready & {NREQ{~rst}};
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) nxt[i]++;
                req_sym[2*i +: 2] = sym_of(i, nxt[i]);
            end
        end
    end

    // Output monitor: compare packer symbols and tags against the scoreboard.
    initial begin : monitor
        logic [1:0]     es;
        logic [IDW-1:0] et;
        forever begin
            @(negedge clk);
            check_eq("rdy_onehot", 32'($countones(req_ready) <= 1), 1);
            if (cons_din_en) begin
                if (sym_q.size() == 0) begin
                    check_eq("din_spurious", cons_din_en, 0);
                end else begin
                    es = sym_q.pop_front();
                    check_eq("cons_din", cons_din, es);
                end
            end
            if (tag_vld) begin
                if (tag_q.size() == 0) begin
                    check_eq("tag_spurious", tag_vld, 0);
                end else begin
                    et = tag_q.pop_front();
                    check_eq("tag_id", tag_id, et);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < NREQ; i++) exp_idx[i] = 0;
        rst          = 1'b1;
        req_valid    = '0;
        cons_dout_en = 1'b0;
        repeat (3) tick();

        // Reset values
        check_eq("rst_din_en", cons_din_en, 0);
        check_eq("rst_din", cons_din, 0);
        check_eq("rst_tag_vld", tag_vld, 0);
        check_eq("rst_tag_id", tag_id, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_tag_err", tag_err, 0);
        check_eq("rst_rdy", req_ready, 0);

        // Byte strobe at reset exit with nothing queued
        rst          = 1'b0;
        cons_dout_en = 1'b1;
        tick();
        cons_dout_en = 1'b0;
        check_eq("uf_err", tag_err, 1);
        check_eq("uf_vld", tag_vld, 0);
        tick();
        check_eq("uf_err_sticky", tag_err, 1);
        check_eq("uf_vld2", tag_vld, 0);

        // Single requester 2, symbols 1,2,3,0
        req_valid = 4'b0100;
        run_burst(2, 1'b0, '0);
        req_valid = '0;
        pulse_dout(1'b1, 2'd2);
        check_eq("t1_err_held", tag_err, 1);

        // Reset in the middle of requester 1's burst
        req_valid = 4'b0010;
        push_syms(1, 2);
        tick();
        check_eq("t6_busy", busy, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("t6_din_en", cons_din_en, 0);
        check_eq("t6_din", cons_din, 0);
        check_eq("t6_busy0", busy, 0);
        check_eq("t6_tag_err", tag_err, 0);
        check_eq("t6_tag_vld", tag_vld, 0);
        check_eq("t6_tag_id", tag_id, 0);
        check_eq("t6_rdy", req_ready, 0);
        rst = 1'b0;

        // All valid: 0,1,2,3,0 with each byte reported during the next grant
        req_valid = 4'b1111;
        run_burst(0, 1'b0, '0);
        run_burst(1, 1'b1, 2'd0);
        run_burst(2, 1'b1, 2'd1);
        run_burst(3, 1'b1, 2'd2);
        run_burst(0, 1'b1, 2'd3);
        req_valid = '0;
        pulse_dout(1'b1, 2'd0);
        check_eq("t2_no_err", tag_err, 0);

        // Stall of requester 1 while requester 3 waits
        req_valid = 4'b1010;
        push_syms(1, 4);
        tick();
        check_eq("t3_busy", busy, 1);
        check_eq("t3_rdy", req_ready, 4'b0010);
        tick();
        tick();
        req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t3_stall_en", cons_din_en, 0);
            check_eq("t3_stall_busy", busy, 1);
            check_eq("t3_stall_rdy", req_ready, 0);
        end
        req_valid = 4'b1010;
        tick();
        tick();
        check_eq("t3_done_busy", busy, 0);
        check_eq("t3_done_rdy", req_ready, 0);
        run_burst(3, 1'b0, '0);
        req_valid = '0;
        pulse_dout(1'b1, 2'd1);
        pulse_dout(1'b1, 2'd3);

        // Credit exhaustion: four bursts, then held until one byte is reported
        req_valid = 4'b1111;
        run_burst(0, 1'b0, '0);
        run_burst(1, 1'b0, '0);
        run_burst(2, 1'b0, '0);
        run_burst(3, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t4_hold_busy", busy, 0);
            check_eq("t4_hold_rdy", req_ready, 0);
        end
        tag_q.push_back(2'd0);
        cons_dout_en = 1'b1;
        tick();
        cons_dout_en = 1'b0;
        check_eq("t4_pop_vld", tag_vld, 1);
        check_eq("t4_pop_busy", busy, 0);
        push_syms(0, 4);
        tick();
        check_eq("t4_regrant_busy", busy, 1);
        check_eq("t4_regrant_rdy", req_ready, 4'b0001);
        repeat (4) tick();
        check_eq("t4_burst5_done", busy, 0);
        req_valid = '0;
        pulse_dout(1'b1, 2'd1);
        pulse_dout(1'b1, 2'd2);
        pulse_dout(1'b1, 2'd3);
        pulse_dout(1'b1, 2'd0);
        check_eq("t4_no_err", tag_err, 0);

        repeat (3) tick();
        check_eq("sym_q_drained", sym_q.size(), 0);
        check_eq("tag_q_drained", tag_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
